// File: rtl/reg_file_seq_pkg.sv
// Shared types and constants for the register-file command sequencer.
// REG_FILE_SEQ_STATS_EN (in the top) adds the STATS_W-wide activity counters.
package reg_file_seq_pkg;

   localparam int unsigned WIDTH_DEF   = 32;
   localparam int unsigned ADDRESS_DEF = 4;
   localparam int unsigned STATS_W     = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ISSUE = ST_ISSUE,
      WAIT  = ST_WAIT,
      RESP  = ST_RESP
   } state_t;

   typedef struct packed {
      logic                   wr;
      logic [ADDRESS_DEF-1:0] addr;
      logic [WIDTH_DEF-1:0]   data;
   } req_t;

endpackage

// File: rtl/reg_file_seq_fifo.sv
// Request FIFO for the sequencer; entry type is a parameter so the top can
// pass a request struct sized to its own WIDTH/ADDRESS.
module reg_file_seq_fifo
   import reg_file_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = req_t
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output T     data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   T           mem_q [DEPTH];
   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop_i  && !empty_o) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

   // Extra pointer bit separates the wrapped-full case from empty.
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/reg_file_seq.sv
// Command sequencer in front of the 16x32 register file: buffers requests,
// issues one strobe at a time, returns read data. REG_FILE_SEQ_STATS_EN adds counters.
module reg_file_seq
   import reg_file_seq_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned ADDRESS    = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_wr,
   input  logic [ADDRESS-1:0] req_addr,
   input  logic [WIDTH-1:0]   req_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [ADDRESS-1:0] rsp_addr,
   output logic [WIDTH-1:0]   rsp_data,
   output logic [WIDTH-1:0]   rf_in_data,
   output logic [ADDRESS-1:0] rf_address,
   output logic               rf_wr_en,
   output logic               rf_rd_en,
   input  logic [WIDTH-1:0]   rf_out_data,
   input  logic               rf_valid_out,
`ifdef REG_FILE_SEQ_STATS_EN
   output logic [STATS_W-1:0] wr_count,
   output logic [STATS_W-1:0] rd_count,
`endif
   output logic               busy,
   output logic               proto_err
);

   typedef struct packed {
      logic               wr;
      logic [ADDRESS-1:0] addr;
      logic [WIDTH-1:0]   data;
   } cmd_t;

   cmd_t head, req_in;
   logic fifo_full, fifo_empty, pop;

   state_t             state_q, state_d;
   logic               cmd_wr_q, cmd_wr_d;
   logic [ADDRESS-1:0] rf_address_q, rf_address_d;
   logic [WIDTH-1:0]   rf_in_data_q, rf_in_data_d;
   logic               rf_wr_en_q, rf_wr_en_d;
   logic               rf_rd_en_q, rf_rd_en_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [ADDRESS-1:0] rsp_addr_q, rsp_addr_d;
   logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic               proto_err_q, proto_err_d;

   assign req_in = '{wr: req_wr, addr: req_addr, data: req_data};

   reg_file_seq_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (cmd_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (req_valid && req_ready),
      .data_i  (req_in),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Gated by rst so req_ready is also low while reset is held.
   assign req_ready = rst && !fifo_full;

   always_comb begin
      state_d      = state_q;
      cmd_wr_d     = cmd_wr_q;
      rf_address_d = rf_address_q;
      rf_in_data_d = rf_in_data_q;
      rf_wr_en_d   = 1'b0;
      rf_rd_en_d   = 1'b0;
      rsp_valid_d  = rsp_valid_q;
      rsp_addr_d   = rsp_addr_q;
      rsp_data_d   = rsp_data_q;
      proto_err_d  = proto_err_q;
      pop          = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop          = 1'b1;
               cmd_wr_d     = head.wr;
               rf_address_d = head.addr;
               rf_in_data_d = head.wr ? head.data : '0;
               rf_wr_en_d   = head.wr;
               rf_rd_en_d   = !head.wr;
               state_d      = ISSUE;
            end
         end
         ISSUE: state_d = cmd_wr_q ? IDLE : WAIT;
         WAIT: begin
            rsp_data_d  = rf_out_data;
            rsp_addr_d  = rf_address_q;
            rsp_valid_d = 1'b1;
            if (!rf_valid_out) proto_err_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cmd_wr_q     <= 1'b0;
         rf_address_q <= '0;
         rf_in_data_q <= '0;
         rf_wr_en_q   <= 1'b0;
         rf_rd_en_q   <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_addr_q   <= '0;
         rsp_data_q   <= '0;
         proto_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_wr_q     <= cmd_wr_d;
         rf_address_q <= rf_address_d;
         rf_in_data_q <= rf_in_data_d;
         rf_wr_en_q   <= rf_wr_en_d;
         rf_rd_en_q   <= rf_rd_en_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_addr_q   <= rsp_addr_d;
         rsp_data_q   <= rsp_data_d;
         proto_err_q  <= proto_err_d;
      end
   end

`ifdef REG_FILE_SEQ_STATS_EN
   logic [STATS_W-1:0] wr_count_q, rd_count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_count_q <= '0;
         rd_count_q <= '0;
      end else begin
         if (state_q == ISSUE && cmd_wr_q && wr_count_q != '1)
            wr_count_q <= wr_count_q + STATS_W'(1);
         if (rsp_valid_q && rsp_ready && rd_count_q != '1)
            rd_count_q <= rd_count_q + STATS_W'(1);
      end
   end

   assign wr_count = wr_count_q;
   assign rd_count = rd_count_q;
`endif

   assign rf_address = rf_address_q;
   assign rf_in_data = rf_in_data_q;
   assign rf_wr_en   = rf_wr_en_q;
   assign rf_rd_en   = rf_rd_en_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_addr   = rsp_addr_q;
   assign rsp_data   = rsp_data_q;
   assign proto_err  = proto_err_q;
   assign busy       = !fifo_empty || (state_q != IDLE);

endmodule
